// File: rtl/zeroheti_dbg_hart_ctrl.sv
// ---------------------------------------------------------------------------
// zeroheti_dbg_hart_ctrl
//
// Debug-side hart control sitting between the debug module and NumHarts
// cores. It does three things:
//   * Turns the level ndmreset request into a stretched hart reset. Every
//     reset event holds the harts in reset for at least RstStretchCycles
//     cycles plus the cycle of the request itself.
//   * Runs one small FSM per hart. The FSM raises the hart's debug request
//     (from debug_req_i, or from halt-on-reset when reset is released) and
//     holds it until the hart reports it is halted.
//   * Flags a hart as unavailable while the harts are in reset, or when a
//     request has gone unacknowledged for AckTimeout cycles.
//
// Handshake: debug_req_o[h] is a request with halted_i[h] as its
// acknowledge. The request rises one cycle after it is accepted. It stays
// high until halted_i[h] is sampled high, and drops on the following cycle.
// A request that came from debug_req_i (not from halt-on-reset) is also
// withdrawn when debug_req_i[h] falls before the acknowledge arrives.
//
// Ports:
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   dmactive_i       debug module active; low aborts every pending request
//   ndmreset_req_i   level non-debug-module reset request
//   debug_req_i      per-hart halt request from the debug module
//   haltonreset_i    per-hart halt-on-reset enable, sampled in RELEASE
//   halted_i         per-hart "in debug mode" (halt acknowledge)
//   hart_rst_no      registered active-low reset to all harts
//   debug_req_o      registered per-hart debug request to the cores
//   unavailable_o    registered per-hart unavailable flag to the debug module
//   ndmreset_busy_o  registered; high while the reset FSM is not in IDLE
// ---------------------------------------------------------------------------
module zeroheti_dbg_hart_ctrl #(
   parameter int unsigned NumHarts         = 1,
   parameter int unsigned RstStretchCycles = 16,
   parameter int unsigned AckTimeout       = 1024
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                dmactive_i,
   input  logic                ndmreset_req_i,
   input  logic [NumHarts-1:0] debug_req_i,
   input  logic [NumHarts-1:0] haltonreset_i,
   input  logic [NumHarts-1:0] halted_i,
   output logic                hart_rst_no,
   output logic [NumHarts-1:0] debug_req_o,
   output logic [NumHarts-1:0] unavailable_o,
   output logic                ndmreset_busy_o
);

   localparam int unsigned RstCntW = $clog2(RstStretchCycles + 1);
   localparam int unsigned AckCntW = $clog2(AckTimeout + 1);
   localparam logic [RstCntW-1:0] RstCntMax = RstCntW'(RstStretchCycles);
   localparam logic [AckCntW-1:0] AckCntMax = AckCntW'(AckTimeout);

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      IDLE    = 2'd2
   } rst_state_e;

   typedef enum logic [1:0] {
      H_IDLE   = 2'd0,
      H_REQ    = 2'd1,
      H_HALTED = 2'd2
   } hart_state_e;

   // ------------------------------------------------------------------
   // Reset FSM
   // ------------------------------------------------------------------
   rst_state_e           rst_state_q, rst_state_d;
   logic [RstCntW-1:0]   rst_cnt_q, rst_cnt_d;
   logic                 rel_pulse;

   always_comb begin
      rst_state_d = rst_state_q;
      rst_cnt_d   = rst_cnt_q;
      rel_pulse   = 1'b0;
      unique case (rst_state_q)
         HOLD: begin
            // Count first, then wait for the request to go away. A request
            // that stays high keeps the harts in reset indefinitely.
            if (rst_cnt_q != RstCntMax) begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end else if (!ndmreset_req_i) begin
               rst_state_d = RELEASE;
            end
         end
         RELEASE: begin
            rel_pulse   = 1'b1;
            rst_state_d = IDLE;
         end
         IDLE: begin
            if (ndmreset_req_i) begin
               rst_state_d = HOLD;
               rst_cnt_d   = '0;
            end
         end
         default: begin
            rst_state_d = HOLD;
            rst_cnt_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Per-hart request FSMs
   // ------------------------------------------------------------------
   hart_state_e          hart_state_q [NumHarts];
   hart_state_e          hart_state_d [NumHarts];
   logic [AckCntW-1:0]   ack_cnt_q    [NumHarts];
   logic [AckCntW-1:0]   ack_cnt_d    [NumHarts];
   logic [NumHarts-1:0]  hor_q, hor_d;
   logic                 hart_force;

   // While the harts are held in reset, or the debug module is inactive,
   // every hart FSM goes back to idle. This overrides all per-hart events.
   assign hart_force = (rst_state_q == HOLD) || !dmactive_i;

   always_comb begin
      hart_state_d = hart_state_q;
      ack_cnt_d    = ack_cnt_q;
      hor_d        = hor_q;
      for (int unsigned h = 0; h < NumHarts; h++) begin
         if (hart_force) begin
            hart_state_d[h] = H_IDLE;
            ack_cnt_d[h]    = '0;
            hor_d[h]        = 1'b0;
         end else begin
            unique case (hart_state_q[h])
               H_IDLE: begin
                  if (rel_pulse && haltonreset_i[h]) begin
                     hart_state_d[h] = H_REQ;
                     hor_d[h]        = 1'b1;
                     ack_cnt_d[h]    = '0;
                  end else if (debug_req_i[h]) begin
                     hart_state_d[h] = H_REQ;
                     hor_d[h]        = 1'b0;
                     ack_cnt_d[h]    = '0;
                  end
               end
               H_REQ: begin
                  // The acknowledge wins over cancellation and over the
                  // timeout reached on the same cycle.
                  if (halted_i[h]) begin
                     hart_state_d[h] = H_HALTED;
                     hor_d[h]        = 1'b0;
                     ack_cnt_d[h]    = '0;
                  end else if (!hor_q[h] && !debug_req_i[h]) begin
                     // A halt-on-reset request has no debug_req_i behind it,
                     // so only a debug_req_i request can be withdrawn.
                     hart_state_d[h] = H_IDLE;
                     ack_cnt_d[h]    = '0;
                  end else if (ack_cnt_q[h] != AckCntMax) begin
                     ack_cnt_d[h] = ack_cnt_q[h] + 1'b1;
                  end
               end
               H_HALTED: begin
                  if (!halted_i[h]) begin
                     hart_state_d[h] = H_IDLE;
                  end
               end
               default: begin
                  hart_state_d[h] = H_IDLE;
                  ack_cnt_d[h]    = '0;
                  hor_d[h]        = 1'b0;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Output next-state. The outputs are registered from the next state,
   // so each one follows its FSM state with no extra cycle of delay.
   // ------------------------------------------------------------------
   logic                hart_rst_n_d;
   logic                busy_d;
   logic [NumHarts-1:0] debug_req_d;
   logic [NumHarts-1:0] unavailable_d;

   always_comb begin
      hart_rst_n_d  = (rst_state_d != HOLD);
      busy_d        = (rst_state_d != IDLE);
      debug_req_d   = '0;
      unavailable_d = '0;
      for (int unsigned h = 0; h < NumHarts; h++) begin
         debug_req_d[h]   = (hart_state_d[h] == H_REQ);
         unavailable_d[h] = busy_d ||
                            ((hart_state_d[h] == H_REQ) && (ack_cnt_d[h] == AckCntMax));
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   logic                hart_rst_n_q;
   logic                busy_q;
   logic [NumHarts-1:0] debug_req_q;
   logic [NumHarts-1:0] unavailable_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rst_state_q   <= HOLD;
         rst_cnt_q     <= '0;
         hart_state_q  <= '{default: H_IDLE};
         ack_cnt_q     <= '{default: '0};
         hor_q         <= '0;
         hart_rst_n_q  <= 1'b0;
         busy_q        <= 1'b1;
         debug_req_q   <= '0;
         unavailable_q <= '1;
      end else begin
         rst_state_q   <= rst_state_d;
         rst_cnt_q     <= rst_cnt_d;
         hart_state_q  <= hart_state_d;
         ack_cnt_q     <= ack_cnt_d;
         hor_q         <= hor_d;
         hart_rst_n_q  <= hart_rst_n_d;
         busy_q        <= busy_d;
         debug_req_q   <= debug_req_d;
         unavailable_q <= unavailable_d;
      end
   end

   assign hart_rst_no     = hart_rst_n_q;
   assign ndmreset_busy_o = busy_q;
   assign debug_req_o     = debug_req_q;
   assign unavailable_o   = unavailable_q;

endmodule

// File: tb/tb_zeroheti_dbg_hart_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for zeroheti_dbg_hart_ctrl (NumHarts=2, RstStretchCycles=16,
// AckTimeout=8). The reference model below describes the block in terms of
// "harts are held in reset", "request pending for N cycles" and "hart
// halted", and is stepped once per clock edge alongside the DUT.
// ---------------------------------------------------------------------------
module tb_zeroheti_dbg_hart_ctrl;

   localparam int NH  = 2;
   localparam int RST = 16;
   localparam int ACK = 8;

   // ------------------------------------------------------------------
   // Clock / reset / DUT
   // ------------------------------------------------------------------
   logic          clk = 1'b0;
   logic          rst_n;
   logic          dmactive;
   logic          ndm;
   logic [NH-1:0] dreq;
   logic [NH-1:0] hor_en;
   logic [NH-1:0] halted;
   logic          hart_rst_n;
   logic          busy;
   logic [NH-1:0] dbg;
   logic [NH-1:0] unav;

   always #5 clk = ~clk;

   zeroheti_dbg_hart_ctrl #(
      .NumHarts         (NH),
      .RstStretchCycles (RST),
      .AckTimeout       (ACK)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .dmactive_i      (dmactive),
      .ndmreset_req_i  (ndm),
      .debug_req_i     (dreq),
      .haltonreset_i   (hor_en),
      .halted_i        (halted),
      .hart_rst_no     (hart_rst_n),
      .debug_req_o     (dbg),
      .unavailable_o   (unav),
      .ndmreset_busy_o (busy)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   logic [2*NH+1:0] exp_q[$];

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   bit          m_hold;      // harts held in reset
   bit          m_rel;       // the single release cycle
   int          m_hcnt;      // edges spent holding
   bit [NH-1:0] m_req;       // request outstanding
   bit [NH-1:0] m_hor;       // request came from halt-on-reset
   bit [NH-1:0] m_hlt;       // hart acknowledged, waiting for it to resume
   int          m_wait[NH];  // cycles the request has gone unacknowledged

   function automatic void model_reset();
      m_hold = 1'b1;
      m_rel  = 1'b0;
      m_hcnt = 0;
      m_req  = '0;
      m_hor  = '0;
      m_hlt  = '0;
      for (int h = 0; h < NH; h++) m_wait[h] = 0;
   endfunction

   function automatic void model_edge();
      bit was_hold;
      bit was_rel;
      was_hold = m_hold;
      was_rel  = m_rel;
      if (was_hold) begin
         if (m_hcnt >= RST && !ndm) begin
            m_hold = 1'b0;
            m_rel  = 1'b1;
         end else begin
            m_hcnt++;
         end
      end else if (was_rel) begin
         m_rel = 1'b0;
      end else if (ndm) begin
         m_hold = 1'b1;
         m_hcnt = 0;
      end
      for (int h = 0; h < NH; h++) begin
         if (was_hold || !dmactive) begin
            m_req[h] = 1'b0; m_hor[h] = 1'b0; m_hlt[h] = 1'b0; m_wait[h] = 0;
         end else if (m_req[h]) begin
            if (halted[h]) begin
               m_req[h] = 1'b0; m_hlt[h] = 1'b1;
            end else if (!m_hor[h] && !dreq[h]) begin
               m_req[h] = 1'b0;
            end else begin
               m_wait[h]++;
            end
         end else if (m_hlt[h]) begin
            if (!halted[h]) m_hlt[h] = 1'b0;
         end else if (was_rel && hor_en[h]) begin
            m_req[h] = 1'b1; m_hor[h] = 1'b1; m_wait[h] = 0;
         end else if (dreq[h]) begin
            m_req[h] = 1'b1; m_hor[h] = 1'b0; m_wait[h] = 0;
         end
      end
   endfunction

   function automatic logic [NH-1:0] model_unav();
      logic [NH-1:0] r;
      for (int h = 0; h < NH; h++)
         r[h] = m_hold || m_rel || (m_req[h] && (m_wait[h] >= ACK));
      return r;
   endfunction

   // One clock edge: advance the model with the inputs seen at the edge,
   // then return 1 time unit later so outputs are sampled off the edge.
   task automatic step();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_edge();
      #1;
   endtask

   // ------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------
   task automatic test_reset();
      int low;
      rst_n = 1'b0; dmactive = 1'b1; ndm = 1'b0;
      dreq = '0; hor_en = '0; halted = '0;
      model_reset();
      repeat (3) step();
      n_cmp++; if (hart_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_rst_n: got %b want 0", hart_rst_n); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
      n_cmp++; if (unav !== 2'b11) begin n_fail++; $display("FAIL reset_unav: got %b want 11", unav); end
      n_cmp++; if (dbg !== 2'b00) begin n_fail++; $display("FAIL reset_dbg: got %b want 00", dbg); end
      rst_n = 1'b1;
      low = 1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (hart_rst_n === 1'b1) break;
         low++;
      end
      n_cmp++; if (low !== RST + 1) begin n_fail++; $display("FAIL por_low_cycles: got %0d want %0d", low, RST + 1); end
      n_cmp++; if (unav !== 2'b11) begin n_fail++; $display("FAIL por_release_unav: got %b want 11", unav); end
      step();
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL por_idle_busy: got %b want 0", busy); end
      n_cmp++; if (unav !== 2'b00) begin n_fail++; $display("FAIL por_idle_unav: got %b want 00", unav); end
   endtask

   task automatic test_ndmreset();
      int low;
      ndm = 1'b1;
      step();
      ndm = 1'b0;
      low = 1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (hart_rst_n === 1'b1) break;
         low++;
      end
      n_cmp++; if (low !== RST + 1) begin n_fail++; $display("FAIL ndm_pulse_low: got %0d want %0d", low, RST + 1); end
      step();
      ndm = 1'b1;
      repeat (40) step();
      n_cmp++; if (hart_rst_n !== 1'b0) begin n_fail++; $display("FAIL ndm_held_low: got %b want 0", hart_rst_n); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ndm_held_busy: got %b want 1", busy); end
      ndm = 1'b0;
      step();
      n_cmp++; if (hart_rst_n !== 1'b1) begin n_fail++; $display("FAIL ndm_held_rise: got %b want 1", hart_rst_n); end
      step();
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ndm_held_idle: got %b want 0", busy); end
   endtask

   task automatic test_halt_on_reset();
      bit up;
      hor_en = 2'b10;
      ndm = 1'b1;
      step();
      ndm = 1'b0;
      up = 1'b0;
      for (int i = 0; i < 60 && !up; i++) begin
         step();
         up = (hart_rst_n === 1'b1);
      end
      n_cmp++; if (!up) begin n_fail++; $display("FAIL hor_release_timeout: got low want high within 60"); end
      n_cmp++; if (dbg !== 2'b00) begin n_fail++; $display("FAIL hor_release_dbg: got %b want 00", dbg); end
      step();
      n_cmp++; if (dbg !== 2'b10) begin n_fail++; $display("FAIL hor_dbg: got %b want 10", dbg); end
      n_cmp++; if (unav !== 2'b00) begin n_fail++; $display("FAIL hor_unav: got %b want 00", unav); end
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++; if (dbg !== 2'b10) begin n_fail++; $display("FAIL hor_hold_%0d: got %b want 10", i, dbg); end
      end
      halted = 2'b10;
      step();
      n_cmp++; if (dbg !== 2'b00) begin n_fail++; $display("FAIL hor_ack: got %b want 00", dbg); end
      halted = '0; hor_en = '0;
      step();
   endtask

   task automatic test_ack_timeout();
      dreq = 2'b01;
      step();
      n_cmp++; if (dbg !== 2'b01) begin n_fail++; $display("FAIL to_rise: got %b want 01", dbg); end
      for (int k = 1; k <= ACK; k++) begin
         step();
         n_cmp++; if (unav[0] !== (k == ACK)) begin n_fail++; $display("FAIL to_unav_k%0d: got %b want %b", k, unav[0], k == ACK); end
         n_cmp++; if (dbg !== 2'b01) begin n_fail++; $display("FAIL to_dbg_k%0d: got %b want 01", k, dbg); end
      end
      step();
      n_cmp++; if (unav !== 2'b01) begin n_fail++; $display("FAIL to_sat: got %b want 01", unav); end
      halted = 2'b01; dreq = '0;
      step();
      n_cmp++; if (unav !== 2'b00) begin n_fail++; $display("FAIL to_ack_unav: got %b want 00", unav); end
      n_cmp++; if (dbg !== 2'b00) begin n_fail++; $display("FAIL to_ack_dbg: got %b want 00", dbg); end
      halted = '0;
      step();
   endtask

   task automatic test_abort();
      dreq = 2'b01;
      step();
      repeat (ACK) step();
      n_cmp++; if (unav !== 2'b01) begin n_fail++; $display("FAIL ab_flag: got %b want 01", unav); end
      dmactive = 1'b0;
      step();
      n_cmp++; if (dbg !== 2'b00) begin n_fail++; $display("FAIL ab_dbg: got %b want 00", dbg); end
      n_cmp++; if (unav !== 2'b00) begin n_fail++; $display("FAIL ab_unav: got %b want 00", unav); end
      dmactive = 1'b1;
      step();
      n_cmp++; if (dbg !== 2'b01) begin n_fail++; $display("FAIL ab_rereq: got %b want 01", dbg); end
      for (int k = 1; k <= ACK; k++) begin
         step();
         n_cmp++; if (unav[0] !== (k == ACK)) begin n_fail++; $display("FAIL ab_restart_k%0d: got %b want %b", k, unav[0], k == ACK); end
      end
      dreq = '0;
      step();
      n_cmp++; if (dbg !== 2'b00) begin n_fail++; $display("FAIL ab_cancel_dbg: got %b want 00", dbg); end
      n_cmp++; if (unav !== 2'b00) begin n_fail++; $display("FAIL ab_cancel_unav: got %b want 00", unav); end
   endtask

   task automatic test_cancel_simul();
      logic seen;
      dreq = 2'b01;
      step();
      n_cmp++; if (dbg !== 2'b01) begin n_fail++; $display("FAIL cn_rise: got %b want 01", dbg); end
      repeat (3) step();
      dreq = '0;
      step();
      n_cmp++; if (dbg !== 2'b00) begin n_fail++; $display("FAIL cn_cancel: got %b want 00", dbg); end
      dreq = 2'b01;
      step();
      seen = 1'b0;
      for (int k = 1; k < ACK; k++) begin
         step();
         seen = seen | unav[0];
      end
      halted = 2'b01;
      step();
      seen = seen | unav[0];
      n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL cn_simul_unav: got %b want 0", seen); end
      n_cmp++; if (dbg !== 2'b00) begin n_fail++; $display("FAIL cn_simul_dbg: got %b want 00", dbg); end
      halted = '0; dreq = '0;
      step();
   endtask

   task automatic test_random();
      logic [2*NH+1:0] exp;
      logic [2*NH+1:0] got;
      for (int c = 0; c < 3000; c++) begin
         ndm      = ($urandom_range(0, 199) == 0);
         dmactive = ($urandom_range(0, 63) != 0);
         if ($urandom_range(0, 7) == 0)  dreq   = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 5) == 0)  halted = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) hor_en = 2'($urandom_range(0, 3));
         step();
         exp_q.push_back({!m_hold, m_hold || m_rel, model_unav(), m_req});
         exp = exp_q.pop_front();
         got = {hart_rst_n, busy, unav, dbg};
         n_cmp++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL rand_c%0d {rst_n,busy,unav,dbg}: got %b want %b", c, got, exp);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_ndmreset();
      test_halt_on_reset();
      test_ack_timeout();
      test_abort();
      test_cancel_simul();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
